// File: rtl/neptune_stack_pkg.sv
// Shared definitions for the Neptune I stack and its arbiter.
package neptune_stack_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_DEPTH     = 256;
    localparam int DEF_ADD_WIDTH = 8;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: when both ports request, the one not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_q, last_d;

    always_comb begin
        gnt_valid = en && (req != 2'b00);
        gnt_id    = req[1] && (!req[0] || !last_q);
        last_d    = upd ? upd_id : last_q;
    end

    // Last grant resets to port 1 so that port 0 wins the first contest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Serialises core and interrupt-unit requests onto the shared LIFO stack,
// guarding against overflow/underflow with a shadow occupancy counter.
module stack_arbiter
    import neptune_stack_pkg::*;
#(
    parameter int width     = DEF_WIDTH,
    parameter int depth     = DEF_DEPTH,
    parameter int add_width = DEF_ADD_WIDTH,
    parameter int rd_lat    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 op0,
    input  logic [width-1:0]     wdata0,
    output logic                 done0,
    output logic                 err0,
    output logic [width-1:0]     rdata0,
    input  logic                 req1,
    input  logic                 op1,
    input  logic [width-1:0]     wdata1,
    output logic                 done1,
    output logic                 err1,
    output logic [width-1:0]     rdata1,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [width-1:0]     stk_wr,
    input  logic [width-1:0]     stk_rd,
    output logic [add_width:0]   stk_count,
    output logic                 fault,
    input  logic                 fault_clr
);

    localparam logic [add_width:0] FULL     = (add_width + 1)'(depth);
    localparam logic [1:0]         LAT_LAST = 2'(rd_lat - 1);

    state_t             state_q, state_d;
    logic               id_q, id_d;
    logic               op_q, op_d;
    logic               err_q, err_d;
    logic [width-1:0]   wdata_q, wdata_d;
    logic [1:0]         lat_q, lat_d;
    logic [add_width:0] count_q, count_d;
    logic               fault_q, fault_d;
    logic [width-1:0]   rdata0_q, rdata0_d;
    logic [width-1:0]   rdata1_q, rdata1_d;

    logic gnt_valid, gnt_id, arb_upd, reject;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == IDLE),
        .req       ({req1, req0}),
        .upd       (arb_upd),
        .upd_id    (id_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        id_d     = id_q;
        op_d     = op_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        count_d  = count_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        done0    = 1'b0;
        done1    = 1'b0;
        err0     = 1'b0;
        err1     = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_wr   = '0;
        arb_upd  = 1'b0;
        reject   = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    op_d    = gnt_id ? op1 : op0;
                    wdata_d = gnt_id ? wdata1 : wdata0;
                    // Boundary violations never reach the stack; they answer straight away.
                    if ((op_d == OP_PUSH && count_q == FULL) ||
                        (op_d == OP_POP  && count_q == '0)) begin
                        reject  = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (op_q == OP_PUSH) begin
                    stk_push = 1'b1;
                    stk_wr   = wdata_q;
                    count_d  = count_q + 1'b1;
                    state_d  = RESP;
                end else begin
                    stk_pop  = 1'b1;
                    count_d  = count_q - 1'b1;
                    lat_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    if (id_q) rdata1_d = stk_rd;
                    else      rdata0_d = stk_rd;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RESP: begin
                done0   = !id_q;
                done1   = id_q;
                err0    = !id_q && err_q;
                err1    = id_q && err_q;
                arb_upd = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A rejection in the same cycle as a clear leaves the fault set.
        if (reject)         fault_d = 1'b1;
        else if (fault_clr) fault_d = 1'b0;
        else                fault_d = fault_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            id_q     <= 1'b0;
            op_q     <= OP_POP;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            lat_q    <= '0;
            count_q  <= '0;
            fault_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            op_q     <= op_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign stk_count = count_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench: two arbiter builds (rd_lat 1 and 3), each driving a behavioural stack,
// checked against a queue-based LIFO model with round-robin grant prediction.
module tb_stack_arbiter;
    import neptune_stack_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_v    [2];
    logic          req0_v   [2];
    logic          op0_v    [2];
    logic [W-1:0]  wd0      [2];
    logic          done0_v  [2];
    logic          err0_v   [2];
    logic [W-1:0]  rd0      [2];
    logic          req1_v   [2];
    logic          op1_v    [2];
    logic [W-1:0]  wd1      [2];
    logic          done1_v  [2];
    logic          err1_v   [2];
    logic [W-1:0]  rd1      [2];
    logic          push_v   [2];
    logic          pop_v    [2];
    logic [W-1:0]  wr       [2];
    logic [W-1:0]  srd      [2];
    logic [8:0]    cnt      [2];
    logic          fault_v  [2];
    logic          fclr_v   [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        stack_arbiter #(
            .width(W), .depth(DEPTH), .add_width(8), .rd_lat(g == 0 ? 1 : 3)
        ) u_dut (
            .clk(clk), .rst(rst_v[g]),
            .req0(req0_v[g]), .op0(op0_v[g]), .wdata0(wd0[g]),
            .done0(done0_v[g]), .err0(err0_v[g]), .rdata0(rd0[g]),
            .req1(req1_v[g]), .op1(op1_v[g]), .wdata1(wd1[g]),
            .done1(done1_v[g]), .err1(err1_v[g]), .rdata1(rd1[g]),
            .stk_push(push_v[g]), .stk_pop(pop_v[g]), .stk_wr(wr[g]),
            .stk_rd(srd[g]), .stk_count(cnt[g]),
            .fault(fault_v[g]), .fault_clr(fclr_v[g])
        );

        // Behavioural LIFO; popped word appears rd_lat cycles after the pop strobe.
        logic [W-1:0] mem  [DEPTH];
        logic [W-1:0] pipe [3];
        int sp, push_cnt, pop_cnt;

        always @(posedge clk or negedge rst_v[g]) begin
            if (!rst_v[g]) begin
                sp       <= 0;
                push_cnt <= 0;
                pop_cnt  <= 0;
                for (int i = 0; i < 3; i++) pipe[i] <= 16'hDEAD;
            end else begin
                pipe[0] <= pop_v[g] ? mem[8'(sp - 1)] : 16'hDEAD;
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
                if (push_v[g]) begin
                    mem[8'(sp)] <= wr[g];
                    sp          <= sp + 1;
                    push_cnt    <= push_cnt + 1;
                end else if (pop_v[g]) begin
                    sp      <= sp - 1;
                    pop_cnt <= pop_cnt + 1;
                end
            end
        end
        assign srd[g] = pipe[g == 0 ? 0 : 2];

        always @(negedge clk)
            if (push_v[g] || pop_v[g])
                check("strobe_excl", {31'b0, push_v[g] & pop_v[g]}, 32'd0);
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int pushes(input int d);
        return (d == 0) ? g_dut[0].push_cnt : g_dut[1].push_cnt;
    endfunction

    function automatic int pops(input int d);
        return (d == 0) ? g_dut[0].pop_cnt : g_dut[1].pop_cnt;
    endfunction

    // Reference model: plain LIFO queue, last-grant bit, sticky fault.
    logic [W-1:0] mstk [$];
    bit           m_last;
    bit           m_fault;

    task automatic model_reset();
        mstk.delete();
        m_last  = 1'b1;
        m_fault = 1'b0;
    endtask

    task automatic check_zero(input int d);
        check("rst_done_err", {28'b0, done0_v[d], err0_v[d], done1_v[d], err1_v[d]}, 32'd0);
        check("rst_strobes", {30'b0, push_v[d], pop_v[d]}, 32'd0);
        check("rst_stk_wr", {16'b0, wr[d]}, 32'd0);
        check("rst_rdata0", {16'b0, rd0[d]}, 32'd0);
        check("rst_rdata1", {16'b0, rd1[d]}, 32'd0);
        check("rst_count", {23'b0, cnt[d]}, 32'd0);
        check("rst_fault", {31'b0, fault_v[d]}, 32'd0);
    endtask

    // One arbitration round: 1 or 2 requesters, optional fault_clr in the first cycle.
    task automatic run_txn(input int d, input bit r0, input bit r1, input bit o0, input bit o1,
                           input logic [W-1:0] w0, input logic [W-1:0] w1, input bit clr);
        bit           rq [2];
        bit           op [2];
        logic [W-1:0] wd [2];
        bit           exp_err [2];
        logic [W-1:0] exp_rd [2];
        int           exp_lat [2];
        bit           seen [2];
        int           win, t, p, cyc, push0, pop0, exp_push, exp_pop;
        logic         dn, er;
        logic [W-1:0] rv;

        rq = '{r0, r1};
        op = '{o0, o1};
        wd = '{w0, w1};
        exp_err = '{0, 0};
        exp_rd  = '{16'h0, 16'h0};
        exp_lat = '{0, 0};
        seen    = '{0, 0};
        exp_push = 0;
        exp_pop  = 0;

        if (clr) m_fault = 1'b0;
        win = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
        t = 0;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? win : 1 - win;
            if (rq[p]) begin
                if ((op[p] && mstk.size() == DEPTH) || (!op[p] && mstk.size() == 0)) begin
                    exp_err[p] = 1'b1;
                    exp_lat[p] = t + 1;
                    m_fault    = 1'b1;
                end else if (op[p]) begin
                    mstk.push_back(wd[p]);
                    exp_lat[p] = t + 2;
                    exp_push++;
                end else begin
                    exp_rd[p]  = mstk.pop_back();
                    exp_lat[p] = t + 2 + lat_of(d);
                    exp_pop++;
                end
                t = exp_lat[p] + 1;
                m_last = (p == 1);
            end
        end

        push0 = pushes(d);
        pop0  = pops(d);
        req0_v[d] = r0; op0_v[d] = o0; wd0[d] = w0;
        req1_v[d] = r1; op1_v[d] = o1; wd1[d] = w1;
        fclr_v[d] = clr;
        cyc = 0;
        while (!((seen[0] || !rq[0]) && (seen[1] || !rq[1])) && cyc < 64) begin
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
                dn = (q == 0) ? done0_v[d] : done1_v[d];
                er = (q == 0) ? err0_v[d]  : err1_v[d];
                rv = (q == 0) ? rd0[d]     : rd1[d];
                if (dn) begin
                    if (rq[q] && !seen[q]) begin
                        seen[q] = 1'b1;
                        check($sformatf("latency_p%0d", q), cyc, exp_lat[q]);
                        check($sformatf("err_p%0d", q), {31'b0, er}, {31'b0, exp_err[q]});
                        if (!op[q] && !exp_err[q])
                            check($sformatf("rdata_p%0d", q), {16'b0, rv}, {16'b0, exp_rd[q]});
                    end else begin
                        check($sformatf("spurious_done_p%0d", q), 32'd1, 32'd0);
                    end
                end
            end
            @(posedge clk);
            #1;
            fclr_v[d] = 1'b0;
            if (seen[0]) req0_v[d] = 1'b0;
            if (seen[1]) req1_v[d] = 1'b0;
            cyc++;
        end
        for (int q = 0; q < 2; q++)
            if (rq[q] && !seen[q]) check($sformatf("timeout_p%0d", q), 32'd0, 32'd1);
        req0_v[d] = 1'b0;
        req1_v[d] = 1'b0;

        check("count", {23'b0, cnt[d]}, 32'(mstk.size()));
        check("fault", {31'b0, fault_v[d]}, {31'b0, m_fault});
        check("push_strobes", 32'(pushes(d) - push0), 32'(exp_push));
        check("pop_strobes", 32'(pops(d) - pop0), 32'(exp_pop));
    endtask

    task automatic pulse_clr(input int d);
        fclr_v[d] = 1'b1;
        @(posedge clk);
        #1;
        fclr_v[d] = 1'b0;
        m_fault = 1'b0;
        check("fault_clr", {31'b0, fault_v[d]}, 32'd0);
    endtask

    task automatic reset_pulse(input int d);
        rst_v[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_v[d] = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("reset_pulse_count", {23'b0, cnt[d]}, 32'd0);
    endtask

    // Starts a pop, then pulls reset low once the FSM has reached WAIT.
    task automatic reset_mid(input int d, input int cycles_in);
        run_txn(d, 1, 0, OP_PUSH, OP_PUSH, 16'h5A5A, 16'h0, 0);
        req0_v[d] = 1'b1;
        op0_v[d]  = OP_POP;
        repeat (cycles_in) begin
            @(posedge clk);
            #1;
        end
        rst_v[d] = 1'b0;
        #1;
        check_zero(d);
        req0_v[d] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", {30'b0, done0_v[d], done1_v[d]}, 32'd0);
        end
        rst_v[d] = 1'b1;
        repeat (lat_of(d) + 3) begin
            @(negedge clk);
            check("no_done_after_reset", {30'b0, done0_v[d], done1_v[d]}, 32'd0);
        end
        @(posedge clk);
        #1;
        model_reset();
        check("count_after_reset", {23'b0, cnt[d]}, 32'd0);
    endtask

    task automatic random_txns(input int d, input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(1, 3);
            run_txn(d, r[0], r[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom), $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b0;
            req0_v[d] = 1'b0; op0_v[d] = 1'b0; wd0[d] = '0;
            req1_v[d] = 1'b0; op1_v[d] = 1'b0; wd1[d] = '0;
            fclr_v[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // rd_lat = 1 build
        run_txn(0, 1, 0, OP_PUSH, OP_PUSH, 16'hA5A5, 16'h0, 0);
        run_txn(0, 1, 0, OP_POP, OP_POP, 16'h0, 16'h0, 0);
        run_txn(0, 1, 0, OP_POP, OP_POP, 16'h0, 16'h0, 0);
        pulse_clr(0);

        reset_pulse(0);
        for (int i = 0; i < 4; i++)
            run_txn(0, 1, 1, OP_PUSH, OP_PUSH, 16'(i + 1), 16'(100 + i), 0);
        for (int i = 0; i < 8; i++)
            run_txn(0, i % 2 == 0, i % 2 == 1, OP_POP, OP_POP, 16'h0, 16'h0, 0);

        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 1) == 0)
                run_txn(0, 1, 0, OP_PUSH, OP_PUSH, 16'($urandom), 16'h0, 0);
            else
                run_txn(0, 0, 1, OP_PUSH, OP_PUSH, 16'h0, 16'($urandom), 0);
        end
        run_txn(0, 1, 0, OP_PUSH, OP_PUSH, 16'hBEEF, 16'h0, 1);
        run_txn(0, 0, 1, OP_POP, OP_POP, 16'h0, 16'h0, 0);
        random_txns(0, 300);
        reset_mid(0, 2);

        // rd_lat = 3 build
        model_reset();
        run_txn(1, 1, 0, OP_PUSH, OP_PUSH, 16'h1234, 16'h0, 0);
        run_txn(1, 1, 0, OP_POP, OP_POP, 16'h0, 16'h0, 0);
        random_txns(1, 200);
        reset_mid(1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares the Neptune I LIFO stack between two requesters: port 0 is the core (CALL/RET/PUSH/POP) and port 1 is the interrupt unit (context save/restore).
- Serialises requests into single-cycle push/pop strobes toward the stack and tracks occupancy in a shadow counter.
- Rejects overflow and underflow before they reach the stack, raising a sticky fault.
- Returns popped data to the winning requester with a done/err handshake.

Parameters:
- width, 16, stack data width
- depth, 256, stack depth in words
- add_width, 8, stack address width; depth equals 2**add_width
- rd_lat, 1, cycles after the stk_pop cycle before stk_rd holds the popped word (valid range 1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req0  in  1  core request; held until done0
- op0  in  1  core operation: 1 = push, 0 = pop
- wdata0  in  width  core push data
- done0  out  1  core completion pulse, 1 cycle
- err0  out  1  valid with done0; request rejected
- rdata0  out  width  pop data, valid with done0
- req1, op1, wdata1, done1, err1, rdata1: same as port 0, for the interrupt unit
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_wr  out  width  stack write data
- stk_rd  in  width  stack read port
- stk_count  out  add_width+1  current occupancy, 0..depth
- fault  out  1  sticky overflow/underflow flag
- fault_clr  in  1  synchronous clear of fault

Behaviour:
- Reset (rst low, asynchronous):
  - state returns to IDLE, stk_count = 0, fault = 0, last-grant = 1 (so port 0 wins first).
  - All outputs are 0: done*, err*, rdata*, stk_push, stk_pop, stk_wr.
  - Reset asserted mid-transaction aborts it with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, arbitrate round-robin: the port not granted last wins when both request. Latch winner id, op and wdata.
  - Push with stk_count == depth, or pop with stk_count == 0: go to RESP with err set. No stack strobe, count unchanged, fault <= 1.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - Push: stk_push = 1 and stk_wr = latched data; stk_count increments at the end of the cycle; next state is RESP.
  - Pop: stk_pop = 1; stk_count decrements; next state is WAIT.
  - stk_push and stk_pop are never high together and are high only in ISSUE.
- WAIT:
  - Lasts rd_lat cycles, counted by a latency counter.
  - stk_rd is captured into rdata of the winning port on the last WAIT edge; next state is RESP.
- RESP (1 cycle):
  - done of the winning port = 1, err as decided in IDLE.
  - rdata holds its value until that port's next done.
  - Update last-grant, then return to IDLE.
- Latency from the first cycle req is seen in IDLE to done:
  - push: 2 cycles
  - pop: 2 + rd_lat cycles
  - rejected request: 1 cycle
- A req still high in the IDLE cycle after RESP is treated as a new request.
- The non-granted port's req is ignored until the FSM is back in IDLE; its done stays 0.
- fault:
  - set on any rejection; cleared by fault_clr.
  - set has priority when a rejection and fault_clr fall in the same cycle.
- stk_count saturates at 0 and depth by construction: rejected operations never change it.
- The op and wdata inputs are don't-care while req is low.

Decomposition:
- Shared package neptune_stack_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - OP_PUSH = 1, OP_POP = 0
  - default width, depth and add_width constants, shared with the stack.
- One sub-module is natural: rr_arb2, a 2-way round-robin arbiter with a last-grant register and an enable input.

Test Plan:
- Port 0 pushes 16'hA5A5 then pops (rd_lat = 1) -> push done0 at cycle +2 with err0 = 0; pop done0 at cycle +3 with rdata0 = 16'hA5A5; stk_count goes 0 -> 1 -> 0.
- Port 0 pops from an empty stack -> done0 and err0 at cycle +1; stk_pop never asserted; fault = 1; stk_count = 0. A later fault_clr pulse -> fault = 0.
- Both ports request push in the same cycle, repeatedly (port 0 data 1..4, port 1 data 100..103) -> grants alternate 0, 1, 0, 1; stack order is 1, 100, 2, 101, ...; stk_count = 8.
- Push depth words, then one more push -> the extra push gets err with no stk_push strobe; stk_count = 256; fault = 1. Then pop -> returns the last written word; count = 255.
- rst pulled low during WAIT of a pop -> all outputs 0 immediately; no done pulse; stk_count = 0 after release.
- rd_lat = 3 build: pop after pushing 16'h1234 -> done arrives 5 cycles after req with rdata = 16'h1234; stk_push and stk_pop never high together.
